game_status_hub: RTL

- Parametrised front-end and game-state block between board I/O, the CPU status registers and the VGA controller.
- Replaces the fixed 3 fps divider, raw-button/pause wiring and 2-bit lives decoding with one generalised block:
  - N synchronised, debounced inputs with edge pulses
  - a pausable frame tick at a configurable rate
  - a configurable lives counter with a post-hit invulnerability window, game-over detection and restart.

---
 rtl/game_pkg.sv | 14 +
 rtl/input_debouncer.sv | 50 +++++
 rtl/game_status_hub.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game status hub and its helpers.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } game_state_t;

    localparam int IDX_JUMP  = 0;
    localparam int IDX_PAUSE = 1;
    localparam int LIVES_W   = 4;

endpackage

// File: rtl/input_debouncer.sv
// One board input: 2-flop synchroniser, stability-count debouncer and rise detector.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_val;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous pin into the clk domain before anything looks at it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_val  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_val  <= sync_meta;
        end
    end

    // Accept a new level only after it has differed from the current one for the full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_val == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                level      <= sync_val;
                rise       <= sync_val;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_status_hub.sv
// Debounced inputs, pausable frame tick and lives/invulnerability state machine.
module game_status_hub
    import game_pkg::*;
#(
    parameter int SYS_FREQ        = 100000000,
    parameter int FRAME_RATE      = 3,
    parameter int NUM_INPUTS      = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_LIVES       = 3,
    parameter int INVULN_FRAMES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in_raw,
    input  logic                  collision_detected,
    output logic [NUM_INPUTS-1:0] in_level,
    output logic [NUM_INPUTS-1:0] in_rise,
    output logic                  frame_tick,
    output logic                  paused,
    output logic [LIVES_W-1:0]    lives,
    output logic [NUM_LIVES-1:0]  life_leds,
    output logic                  game_over,
    output logic                  hit_pulse
);

    localparam int DIV   = SYS_FREQ / FRAME_RATE;
    localparam int DIV_W = $clog2(DIV);
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);

    game_state_t        state, state_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [INV_W-1:0]   inv_cnt, inv_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               hit_nxt;
    logic               restart;
    logic               col_prev;
    logic               hit_evt;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_inputs
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk  (clk),
            .reset(reset),
            .raw  (in_raw[g]),
            .level(in_level[g]),
            .rise (in_rise[g])
        );
    end

    assign paused  = in_level[IDX_PAUSE];
    assign hit_evt = collision_detected & ~col_prev;

    // Frame divider: the tick is registered one count early so it is high on the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else if (restart) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else if (paused) begin
            frame_tick <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_cnt + 1'b1;
            frame_tick <= (div_cnt == DIV_PRE);
        end
    end

    // Remember last cycle's collision level so a sustained overlap counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_prev <= 1'b0;
        end else begin
            col_prev <= collision_detected;
        end
    end

    // Next-state logic: lose a life on a fresh hit, wait out invulnerability, restart after game over.
    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        inv_nxt   = inv_cnt;
        hit_nxt   = 1'b0;
        restart   = 1'b0;
        case (state)
            PLAY: begin
                if (hit_evt && !paused) begin
                    hit_nxt   = 1'b1;
                    lives_nxt = lives - 1'b1;
                    if (lives == LIVES_W'(1)) begin
                        state_nxt = OVER;
                    end else begin
                        state_nxt = INVULN;
                        inv_nxt   = INV_W'(INVULN_FRAMES);
                    end
                end
            end
            INVULN: begin
                if (frame_tick) begin
                    inv_nxt = inv_cnt - 1'b1;
                    if (inv_cnt == INV_W'(1)) begin
                        state_nxt = PLAY;
                    end
                end
            end
            OVER: begin
                if (in_rise[IDX_JUMP]) begin
                    state_nxt = PLAY;
                    lives_nxt = LIVES_W'(NUM_LIVES);
                    inv_nxt   = '0;
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = PLAY;
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PLAY;
            lives     <= LIVES_W'(NUM_LIVES);
            inv_cnt   <= '0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            lives     <= lives_nxt;
            inv_cnt   <= inv_nxt;
            hit_pulse <= hit_nxt;
        end
    end

    // Display outputs follow the registered lives/state one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            life_leds <= '1;
            game_over <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LIVES; i++) begin
                life_leds[i] <= (lives > LIVES_W'(i));
            end
            game_over <= (state == OVER);
        end
    end

endmodule
